// File: rtl/axis_exp_adc_multi.sv
// ---------------------------------------------------------------------------
// axis_exp_adc_multi
// SPI readout engine for EXP-series ADCs. NUM_CH converters share sck/csn/sdo,
// each returns its result over its own NUM_SDI-lane sdi bus. Register commands
// (24 bit, MSB first) arrive on an AXI-Stream slave; a trigger rising edge
// reads every channel in parallel and emits one AXI-Stream beat per channel.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   spi_sck/csn/sdo      shared SPI clock (idle low), chip select, command data
//   spi_sdi              per-channel data lanes, channel c at [c*NUM_SDI +: NUM_SDI]
//   spi_resetn           ADC reset, released 2 aclk cycles after aresetn
//   trigger, lane_mode   readout start (rising edge) and lane selection
//   s_axis_*             command input, tready is a 1-cycle accept pulse
//   m_axis_*             result beats, tuser = channel, tlast = last channel
//   busy, overrun_cnt    not idle; saturating count of dropped triggers
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | csn high, waiting for trigger edge or command
// SETUP  | csn low, lead-in before the first sck rise
// SHIFT  | sck toggling; sample sdi on rise, advance sdo on fall
// HOLD   | sck low; csn low tail, then csn high recovery time
// EMIT   | streaming one result beat per channel
// ---------------------------------------------------------------------------
module axis_exp_adc_multi #(
    parameter int NUM_SDI    = 4,
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int SCK_DIV    = 1,
    parameter int CH_W       = 3
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    output logic                      spi_sck,
    output logic                      spi_csn,
    output logic                      spi_sdo,
    input  logic [NUM_CH*NUM_SDI-1:0] spi_sdi,
    output logic                      spi_resetn,
    input  logic                      trigger,
    input  logic [1:0]                lane_mode,
    input  logic [31:0]               s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [CH_W-1:0]           m_axis_tuser,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      busy,
    output logic [15:0]               overrun_cnt
);

    localparam int MAX_BITS = (DATA_WIDTH > 24) ? DATA_WIDTH : 24;
    localparam int BIT_W    = $clog2(MAX_BITS);
    localparam int DIV_W    = $clog2(2 * SCK_DIV) + 1;

    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] HOLD_LOAD = DIV_W'(2 * SCK_DIV - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_EMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              rst_sync_q, rst_sync_d;
    logic                    trig_q, trig_d;
    logic                    is_read_q, is_read_d;
    logic [2:0]              lanes_q, lanes_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    hold_phase_q, hold_phase_d;
    logic                    sck_q, sck_d;
    logic                    csn_q, csn_d;
    logic                    sdo_q, sdo_d;
    logic [23:0]             cmd_q, cmd_d;
    logic                    tready_q, tready_d;
    logic [DATA_WIDTH-1:0]   data_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   data_d [NUM_CH];
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [CH_W-1:0]         tuser_q, tuser_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;
    logic [15:0]             ovr_q, ovr_d;

    logic                    trig_edge;
    logic [2:0]              eff_lanes;
    logic [3:0]              lane_v [NUM_CH];
    logic [CH_W-1:0]         next_ch;
    logic [DATA_WIDTH-1:0]   next_beat;
    logic                    unused_tdata;

    assign unused_tdata = ^s_axis_tdata[31:24];

    // Lane L-1 is the most significant bit of each sampled group.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur,
                                                       input logic [3:0]            lanes_in,
                                                       input logic [2:0]            n);
        case (n)
            3'd4:    shift_in = {cur[DATA_WIDTH-5:0], lanes_in};
            3'd2:    shift_in = {cur[DATA_WIDTH-3:0], lanes_in[1:0]};
            default: shift_in = {cur[DATA_WIDTH-2:0], lanes_in[0]};
        endcase
    endfunction

    // Requested lanes clipped to what the devices actually wire up.
    always_comb begin
        eff_lanes = 3'd1;
        case (lane_mode)
            2'd1: if (NUM_SDI >= 2) eff_lanes = 3'd2;
            2'd2: begin
                if (NUM_SDI >= 4)      eff_lanes = 3'd4;
                else if (NUM_SDI >= 2) eff_lanes = 3'd2;
            end
            default: eff_lanes = 3'd1;
        endcase
    end

    // Zero-pad each channel's lanes to 4 so one shifter serves every NUM_SDI.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            lane_v[c]            = '0;
            lane_v[c][NUM_SDI-1:0] = spi_sdi[c*NUM_SDI +: NUM_SDI];
        end
    end

    always_comb begin
        next_ch   = ch_q + CH_W'(1);
        next_beat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (next_ch == CH_W'(c)) next_beat = data_q[c];
        end
    end

    assign trig_edge = trigger & ~trig_q;

    always_comb begin
        state_d      = state_q;
        rst_sync_d   = {rst_sync_q[0], 1'b1};
        trig_d       = trigger;
        is_read_d    = is_read_q;
        lanes_d      = lanes_q;
        div_d        = div_q;
        bit_d        = bit_q;
        hold_phase_d = hold_phase_q;
        sck_d        = sck_q;
        csn_d        = csn_q;
        sdo_d        = sdo_q;
        cmd_d        = cmd_q;
        tready_d     = 1'b0;
        data_d       = data_q;
        ch_d         = ch_q;
        tdata_d      = tdata_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        tvalid_d     = tvalid_q;
        ovr_d        = ovr_q;

        if (trig_edge && (state_q != S_IDLE) && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (trig_edge) begin
                    is_read_d = 1'b1;
                    lanes_d   = eff_lanes;
                    csn_d     = 1'b0;
                    div_d     = DIV_LOAD;
                    state_d   = S_SETUP;
                end else if (s_axis_tvalid) begin
                    is_read_d = 1'b0;
                    cmd_d     = s_axis_tdata[23:0];
                    sdo_d     = s_axis_tdata[23];
                    tready_d  = 1'b1;
                    csn_d     = 1'b0;
                    div_d     = DIV_LOAD;
                    state_d   = S_SETUP;
                end
            end

            S_SETUP: begin
                if (div_q == '0) begin
                    // First rise: counts as period one, so load periods-1.
                    sck_d   = 1'b1;
                    div_d   = DIV_LOAD;
                    state_d = S_SHIFT;
                    if (is_read_q) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            data_d[c] = shift_in(data_q[c], lane_v[c], lanes_q);
                        end
                        case (lanes_q)
                            3'd4:    bit_d = BIT_W'(DATA_WIDTH / 4 - 1);
                            3'd2:    bit_d = BIT_W'(DATA_WIDTH / 2 - 1);
                            default: bit_d = BIT_W'(DATA_WIDTH - 1);
                        endcase
                    end else begin
                        bit_d = BIT_W'(23);
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            S_SHIFT: begin
                if (div_q == '0) begin
                    div_d = DIV_LOAD;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_q == '0) begin
                            sdo_d        = 1'b0;
                            cmd_d        = '0;
                            hold_phase_d = 1'b0;
                            state_d      = S_HOLD;
                        end else if (!is_read_q) begin
                            cmd_d = {cmd_q[22:0], 1'b0};
                            sdo_d = cmd_q[22];
                        end
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q - BIT_W'(1);
                        if (is_read_q) begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                data_d[c] = shift_in(data_q[c], lane_v[c], lanes_q);
                            end
                        end
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            S_HOLD: begin
                if (div_q == '0) begin
                    if (!hold_phase_q) begin
                        csn_d        = 1'b1;
                        hold_phase_d = 1'b1;
                        div_d        = HOLD_LOAD;
                    end else if (is_read_q) begin
                        ch_d     = '0;
                        tdata_d  = data_q[0];
                        tuser_d  = '0;
                        tlast_d  = (NUM_CH == 1);
                        tvalid_d = 1'b1;
                        state_d  = S_EMIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            S_EMIT: begin
                if (m_axis_tready) begin
                    if (ch_q == LAST_CH) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        ch_d    = next_ch;
                        tdata_d = next_beat;
                        tuser_d = next_ch;
                        tlast_d = (next_ch == LAST_CH);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            rst_sync_q   <= '0;
            trig_q       <= 1'b0;
            is_read_q    <= 1'b0;
            lanes_q      <= 3'd1;
            div_q        <= '0;
            bit_q        <= '0;
            hold_phase_q <= 1'b0;
            sck_q        <= 1'b0;
            csn_q        <= 1'b1;
            sdo_q        <= 1'b0;
            cmd_q        <= '0;
            tready_q     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) data_q[c] <= '0;
            ch_q         <= '0;
            tdata_q      <= '0;
            tuser_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            rst_sync_q   <= rst_sync_d;
            trig_q       <= trig_d;
            is_read_q    <= is_read_d;
            lanes_q      <= lanes_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            hold_phase_q <= hold_phase_d;
            sck_q        <= sck_d;
            csn_q        <= csn_d;
            sdo_q        <= sdo_d;
            cmd_q        <= cmd_d;
            tready_q     <= tready_d;
            data_q       <= data_d;
            ch_q         <= ch_d;
            tdata_q      <= tdata_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
            ovr_q        <= ovr_d;
        end
    end

    assign spi_sck       = sck_q;
    assign spi_csn       = csn_q;
    assign spi_sdo       = sdo_q;
    assign spi_resetn    = rst_sync_q[1];
    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != S_IDLE);
    assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_axis_exp_adc_multi.sv
module tb_axis_exp_adc_multi;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        spi_sck, spi_csn, spi_sdo, spi_resetn;
    logic [7:0]  spi_sdi = '0;
    logic        trigger = 1'b0;
    logic [1:0]  lane_mode = 2'd0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [2:0]  m_axis_tuser;
    logic        m_axis_tlast, m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        busy;
    logic [15:0] overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pat [2];
    int          tb_lanes = 1;
    int          k_per = 0;
    logic        prev_csn = 1'b1;
    logic        prev_sck = 1'b0;
    int          rise_cnt = 0;
    logic [23:0] sdo_cap = '0;
    int          tready_pulses = 0;
    logic [31:0] beat_data [64];
    logic [2:0]  beat_user [64];
    logic        beat_last [64];
    int          beat_n = 0;

    always #5 aclk = ~aclk;

    axis_exp_adc_multi dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .spi_sck       (spi_sck),
        .spi_csn       (spi_csn),
        .spi_sdo       (spi_sdo),
        .spi_sdi       (spi_sdi),
        .spi_resetn    (spi_resetn),
        .trigger       (trigger),
        .lane_mode     (lane_mode),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .overrun_cnt   (overrun_cnt)
    );

    // ADC model: presents period k's bits (lane L-1 = MSB) after csn fall / sck fall.
    task automatic drive_sdi(input int k);
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < 4; j++) begin
                int idx;
                idx = 31 - k * tb_lanes - (tb_lanes - 1 - j);
                if (j < tb_lanes && idx >= 0 && idx <= 31) spi_sdi[c*4+j] = pat[c][idx];
                else spi_sdi[c*4+j] = 1'b0;
            end
        end
    endtask

    always @(spi_csn or spi_sck) begin
        if (prev_csn && !spi_csn) begin
            k_per = 0;
            drive_sdi(0);
        end else if (prev_sck && !spi_sck && !spi_csn) begin
            k_per = k_per + 1;
            drive_sdi(k_per);
        end
        if (!prev_sck && spi_sck) begin
            rise_cnt = rise_cnt + 1;
            sdo_cap  = {sdo_cap[22:0], spi_sdo};
        end
        prev_csn = spi_csn;
        prev_sck = spi_sck;
    end

    always @(posedge aclk) begin
        if (s_axis_tready) tready_pulses = tready_pulses + 1;
        if (m_axis_tvalid && m_axis_tready) begin
            beat_data[beat_n & 63] = m_axis_tdata;
            beat_user[beat_n & 63] = m_axis_tuser;
            beat_last[beat_n & 63] = m_axis_tlast;
            beat_n = beat_n + 1;
        end
    end

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge aclk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fire_trigger();
        @(negedge aclk);
        trigger = 1'b1;
        @(negedge aclk);
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        n_checks++;
        if ({spi_csn, spi_sck, spi_sdo, spi_resetn, s_axis_tready, m_axis_tvalid,
             m_axis_tlast, busy} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 10000000",
                     {spi_csn, spi_sck, spi_sdo, spi_resetn, s_axis_tready, m_axis_tvalid,
                      m_axis_tlast, busy});
        end
        n_checks++;
        if ({m_axis_tdata, m_axis_tuser, overrun_cnt} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_data: tdata %h tuser %0d ovr %0d expected all 0",
                     m_axis_tdata, m_axis_tuser, overrun_cnt);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        n_checks++;
        if (spi_resetn !== 1'b0) begin
            n_fail++;
            $display("FAIL resetn_1cyc: got %b expected 0", spi_resetn);
        end
        @(posedge aclk);
        #1;
        n_checks++;
        if (spi_resetn !== 1'b1) begin
            n_fail++;
            $display("FAIL resetn_2cyc: got %b expected 1", spi_resetn);
        end
    endtask

    task automatic test_cmd();
        int  r0, t0;
        bit  ok, seen;
        r0 = rise_cnt;
        t0 = tready_pulses;
        @(negedge aclk);
        s_axis_tdata  = 32'hFFA00000;
        s_axis_tvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        wait_idle(500, ok);
        n_checks++;
        if (!(seen && ok)) begin
            n_fail++;
            $display("FAIL cmd_timeout: tready seen %b idle %b expected 1 1", seen, ok);
        end
        n_checks++;
        if (rise_cnt - r0 !== 24) begin
            n_fail++;
            $display("FAIL cmd_rises: got %0d expected 24", rise_cnt - r0);
        end
        n_checks++;
        if (sdo_cap !== 24'hA00000) begin
            n_fail++;
            $display("FAIL cmd_sdo: got %h expected a00000", sdo_cap);
        end
        n_checks++;
        if (tready_pulses - t0 !== 1) begin
            n_fail++;
            $display("FAIL cmd_tready: got %0d pulses expected 1", tready_pulses - t0);
        end
    endtask

    task automatic test_read_mode(input logic [1:0] mode, input int lanes, input int exp_rises);
        int r0, b0;
        bit ok;
        lane_mode     = mode;
        tb_lanes      = lanes;
        m_axis_tready = 1'b1;
        r0 = rise_cnt;
        b0 = beat_n;
        fire_trigger();
        wait_idle(2000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL read_m%0d_timeout: busy still %b expected 0", mode, busy);
        end
        n_checks++;
        if (rise_cnt - r0 !== exp_rises) begin
            n_fail++;
            $display("FAIL read_m%0d_rises: got %0d expected %0d", mode, rise_cnt - r0, exp_rises);
        end
        n_checks++;
        if (beat_n - b0 !== 2) begin
            n_fail++;
            $display("FAIL read_m%0d_beats: got %0d expected 2", mode, beat_n - b0);
        end
        n_checks++;
        if ({beat_data[b0 & 63], beat_user[b0 & 63], beat_last[b0 & 63]} !== {32'h8BADF00D, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL read_m%0d_beat0: got %h/%0d/%b expected 8badf00d/0/0", mode,
                     beat_data[b0 & 63], beat_user[b0 & 63], beat_last[b0 & 63]);
        end
        n_checks++;
        if ({beat_data[(b0+1) & 63], beat_user[(b0+1) & 63], beat_last[(b0+1) & 63]} !== {32'h0023FF42, 3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL read_m%0d_beat1: got %h/%0d/%b expected 0023ff42/1/1", mode,
                     beat_data[(b0+1) & 63], beat_user[(b0+1) & 63], beat_last[(b0+1) & 63]);
        end
    endtask

    task automatic test_backpressure();
        int b0;
        bit ok, seen, stable;
        lane_mode     = 2'd2;
        tb_lanes      = 4;
        m_axis_tready = 1'b0;
        b0 = beat_n;
        fire_trigger();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid) begin
                seen = 1'b1;
                break;
            end
        end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (i == 5) trigger = 1'b1;
            if (i == 6) trigger = 1'b0;
            if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === 32'h8BADF00D &&
                  m_axis_tuser === 3'd0 && m_axis_tlast === 1'b0)) stable = 1'b0;
        end
        n_checks++;
        if (!(seen && stable)) begin
            n_fail++;
            $display("FAIL bp_hold: valid seen %b stable %b expected 1 1", seen, stable);
        end
        n_checks++;
        if (overrun_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_overrun: got %0d expected 1", overrun_cnt);
        end
        n_checks++;
        if (beat_n - b0 !== 0) begin
            n_fail++;
            $display("FAIL bp_nobeat: got %0d beats expected 0", beat_n - b0);
        end
        m_axis_tready = 1'b1;
        wait_idle(200, ok);
        n_checks++;
        if (!(ok && beat_n - b0 == 2 && beat_data[b0 & 63] === 32'h8BADF00D &&
              beat_data[(b0+1) & 63] === 32'h0023FF42)) begin
            n_fail++;
            $display("FAIL bp_drain: idle %b beats %0d data %h %h expected 1 2 8badf00d 0023ff42",
                     ok, beat_n - b0, beat_data[b0 & 63], beat_data[(b0+1) & 63]);
        end
    endtask

    task automatic test_collision();
        int r0, b0, t0;
        bit ok, seen;
        lane_mode     = 2'd2;
        tb_lanes      = 4;
        m_axis_tready = 1'b1;
        r0 = rise_cnt;
        b0 = beat_n;
        t0 = tready_pulses;
        @(negedge aclk);
        s_axis_tdata  = 32'h005A5A5A;
        s_axis_tvalid = 1'b1;
        trigger       = 1'b1;
        @(negedge aclk);
        trigger = 1'b0;
        wait_idle(500, ok);
        n_checks++;
        if (!(ok && tready_pulses - t0 == 0 && rise_cnt - r0 == 8)) begin
            n_fail++;
            $display("FAIL coll_read_first: idle %b tready %0d rises %0d expected 1 0 8",
                     ok, tready_pulses - t0, rise_cnt - r0);
        end
        n_checks++;
        if (!(beat_n - b0 == 2 && beat_data[b0 & 63] === 32'h8BADF00D &&
              beat_data[(b0+1) & 63] === 32'h0023FF42)) begin
            n_fail++;
            $display("FAIL coll_beats: beats %0d data %h %h expected 2 8badf00d 0023ff42",
                     beat_n - b0, beat_data[b0 & 63], beat_data[(b0+1) & 63]);
        end
        r0 = rise_cnt;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s_axis_tready) begin
                seen = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        wait_idle(500, ok);
        n_checks++;
        if (!(seen && ok && tready_pulses - t0 == 1 && rise_cnt - r0 == 24 && sdo_cap === 24'h5A5A5A)) begin
            n_fail++;
            $display("FAIL coll_cmd: tready %b/%0d idle %b rises %0d sdo %h expected 1/1 1 24 5a5a5a",
                     seen, tready_pulses - t0, ok, rise_cnt - r0, sdo_cap);
        end
    endtask

    task automatic test_reset_mid();
        int r0, b0;
        bit seen;
        lane_mode = 2'd0;
        tb_lanes  = 1;
        r0 = rise_cnt;
        b0 = beat_n;
        fire_trigger();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (rise_cnt - r0 >= 5) begin
                seen = 1'b1;
                break;
            end
        end
        #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (!(seen && spi_csn === 1'b1 && spi_sck === 1'b0 && m_axis_tvalid === 1'b0 && busy === 1'b0)) begin
            n_fail++;
            $display("FAIL rstmid_abort: inshift %b csn %b sck %b tvalid %b busy %b expected 1 1 0 0 0",
                     seen, spi_csn, spi_sck, m_axis_tvalid, busy);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        n_checks++;
        if (beat_n - b0 !== 0) begin
            n_fail++;
            $display("FAIL rstmid_nobeat: got %0d beats expected 0", beat_n - b0);
        end
        test_read_mode(2'd2, 4, 8);
    endtask

    initial begin
        pat[0] = 32'h8BADF00D;
        pat[1] = 32'h0023FF42;
        test_reset();
        test_cmd();
        test_read_mode(2'd2, 4, 8);
        test_read_mode(2'd0, 1, 32);
        test_read_mode(2'd1, 2, 16);
        test_read_mode(2'd3, 1, 32);
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
